// File: rtl/engine_bus_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : engine_bus_arbiter                                         |
// | Description : Round-robin arbiter sharing one Avalon-style memory port   |
// |               (address/read/write/waitrequest, zero-latency readdata)    |
// |               among MASTERS engine cores. A grant lasts for exactly one  |
// |               transaction: until it completes or the master withdraws.   |
// | Ports       : clock, clock_sreset   - clock, sync active-high reset      |
// |               m_address/m_writedata - packed per-master operands         |
// |               m_read/m_write        - per-master requests                |
// |               m_waitrequest         - per-master stall                   |
// |               m_readdata            - s_readdata broadcast               |
// |               s_*                   - shared slave port                  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module engine_bus_arbiter #(
  parameter int WIDTHA  = 12,
  parameter int WIDTHD  = 32,
  parameter int MASTERS = 4
) (
  input  logic                       clock,
  input  logic                       clock_sreset,
  input  logic [MASTERS*WIDTHA-1:0]  m_address,
  input  logic [MASTERS*WIDTHD-1:0]  m_writedata,
  input  logic [MASTERS-1:0]         m_read,
  input  logic [MASTERS-1:0]         m_write,
  output logic [MASTERS-1:0]         m_waitrequest,
  output logic [WIDTHD-1:0]          m_readdata,
  output logic [WIDTHA-1:0]          s_address,
  output logic [WIDTHD-1:0]          s_writedata,
  output logic                       s_read,
  output logic                       s_write,
  input  logic                       s_waitrequest,
  input  logic [WIDTHD-1:0]          s_readdata
);

  localparam int WIDTHG = (MASTERS > 1) ? $clog2(MASTERS) : 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  logic [0:0]         r_state;
  logic [WIDTHG-1:0]  r_grant;
  logic [WIDTHG-1:0]  r_last;
  logic [WIDTHG-1:0]  w_next;
  logic [WIDTHG-1:0]  w_idx;
  logic [MASTERS-1:0] w_req;
  logic               w_any;
  logic               w_done;

  assign w_req      = m_read | m_write;
  assign w_any      = |w_req;
  assign m_readdata = s_readdata;

  // Round-robin search starting just after the last served master. The loop
  // runs from the farthest candidate to the nearest so that the final hit,
  // which wins, is the closest requester after r_last.
  always_comb begin
    w_next = r_last;
    w_idx  = '0;
    for (int k = MASTERS; k >= 1; k--) begin
      w_idx = WIDTHG'((int'(r_last) + k) % MASTERS);
      if (w_req[w_idx]) begin
        w_next = w_idx;
      end
    end
  end

  // Forward the granted master onto the shared port; everyone else stalls.
  always_comb begin
    s_address     = '0;
    s_writedata   = '0;
    s_read        = 1'b0;
    s_write       = 1'b0;
    m_waitrequest = '1;
    for (int i = 0; i < MASTERS; i++) begin
      if ((r_state == ST_BUSY) && (r_grant == WIDTHG'(i))) begin
        s_address        = m_address[i*WIDTHA +: WIDTHA];
        s_writedata      = m_writedata[i*WIDTHD +: WIDTHD];
        s_read           = m_read[i];
        s_write          = m_write[i];
        m_waitrequest[i] = s_waitrequest;
      end
    end
  end

  assign w_done = (s_read | s_write) & ~s_waitrequest;

  // Reset leaves r_last at the top index so master 0 wins the first contention.
  always_ff @(posedge clock) begin
    if (clock_sreset) begin
      r_state <= ST_IDLE;
      r_grant <= '0;
      r_last  <= WIDTHG'(MASTERS - 1);
    end else if (r_state == ST_IDLE) begin
      if (w_any) begin
        r_grant <= w_next;
        r_state <= ST_BUSY;
      end
    end else begin
      // Completion or withdrawal both end the grant; a withdrawn master puts
      // nothing on the slave port since s_read/s_write follow its requests.
      if (!w_req[r_grant] || w_done) begin
        r_state <= ST_IDLE;
        r_last  <= r_grant;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_engine_bus_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_engine_bus_arbiter                                      |
// | Description : Self-checking bench for engine_bus_arbiter: directed      |
// |               scenarios followed by randomized engine traffic, checked  |
// |               every cycle against a transaction-level reference model.  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_engine_bus_arbiter;

  localparam int M  = 4;
  localparam int WA = 12;
  localparam int WD = 32;

  logic              clock = 1'b0;
  logic              clock_sreset;
  logic [M*WA-1:0]   m_address;
  logic [M*WD-1:0]   m_writedata;
  logic [M-1:0]      m_read;
  logic [M-1:0]      m_write;
  logic [M-1:0]      m_waitrequest;
  logic [WD-1:0]     m_readdata;
  logic [WA-1:0]     s_address;
  logic [WD-1:0]     s_writedata;
  logic              s_read;
  logic              s_write;
  logic              s_waitrequest;
  logic [WD-1:0]     s_readdata;

  always #5 clock = ~clock;

  engine_bus_arbiter #(.WIDTHA(WA), .WIDTHD(WD), .MASTERS(M)) dut (
    .clock         (clock),
    .clock_sreset  (clock_sreset),
    .m_address     (m_address),
    .m_writedata   (m_writedata),
    .m_read        (m_read),
    .m_write       (m_write),
    .m_waitrequest (m_waitrequest),
    .m_readdata    (m_readdata),
    .s_address     (s_address),
    .s_writedata   (s_writedata),
    .s_read        (s_read),
    .s_write       (s_write),
    .s_waitrequest (s_waitrequest),
    .s_readdata    (s_readdata)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: is a transaction in flight, whose is it, who was last served.
  bit model_busy;
  int model_owner;
  int model_last;

  int  cyc = 0;
  bit  auto_drop = 1'b1;
  int  dut_log[$];
  int  dut_cyc[$];
  int  exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_pick(input int last, input logic [M-1:0] req);
    for (int k = 1; k <= M; k++) begin
      if (req[(last + k) % M]) return (last + k) % M;
    end
    return -1;
  endfunction

  task automatic req_m(input int i, input bit rd, input bit wr,
                       input logic [WA-1:0] a, input logic [WD-1:0] d);
    m_read[i]              = rd;
    m_write[i]             = wr;
    m_address[i*WA +: WA]  = a;
    m_writedata[i*WD +: WD] = d;
  endtask

  // One clock: check outputs against the model, advance the model at the edge,
  // then retire completed engine requests at the following negedge.
  task automatic cycle();
    logic [M-1:0]  req;
    logic [M-1:0]  ewait;
    logic [WA-1:0] eaddr;
    logic [WD-1:0] edata;
    logic          erd;
    logic          ewr;
    int            done;
    bit            nb;
    int            no;
    int            nl;
    #1;
    req   = m_read | m_write;
    erd   = 1'b0;
    ewr   = 1'b0;
    eaddr = '0;
    edata = '0;
    ewait = '1;
    if (model_busy) begin
      erd   = m_read[model_owner];
      ewr   = m_write[model_owner];
      eaddr = m_address[model_owner*WA +: WA];
      edata = m_writedata[model_owner*WD +: WD];
      ewait[model_owner] = s_waitrequest;
    end
    chk("s_read",        {63'd0, s_read},  {63'd0, erd});
    chk("s_write",       {63'd0, s_write}, {63'd0, ewr});
    chk("s_address",     64'(s_address),     64'(eaddr));
    chk("s_writedata",   64'(s_writedata),   64'(edata));
    chk("m_waitrequest", 64'(m_waitrequest), 64'(ewait));
    chk("m_readdata",    64'(m_readdata),    64'(s_readdata));

    if ((s_read || s_write) && !s_waitrequest) begin
      for (int i = 0; i < M; i++) begin
        if (!m_waitrequest[i]) begin
          dut_log.push_back(i);
          dut_cyc.push_back(cyc);
        end
      end
    end

    done = -1;
    nb   = model_busy;
    no   = model_owner;
    nl   = model_last;
    if (clock_sreset) begin
      nb = 1'b0; no = 0; nl = M - 1;
    end else if (!model_busy) begin
      if (|req) begin
        no = rr_pick(model_last, req);
        nb = 1'b1;
      end
    end else if (!req[model_owner]) begin
      nb = 1'b0; nl = model_owner;
    end else if (!s_waitrequest) begin
      nb = 1'b0; nl = model_owner; done = model_owner;
    end
    @(posedge clock);
    model_busy  = nb;
    model_owner = no;
    model_last  = nl;
    cyc++;
    @(negedge clock);
    if (auto_drop && done >= 0) begin
      m_read[done]  = 1'b0;
      m_write[done] = 1'b0;
    end
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while ((|(m_read | m_write)) && n < budget) begin
      cycle();
      n++;
    end
    chk(tag, {63'd0, n < budget}, 64'd1);
  endtask

  task automatic check_log(input string tag, input int exp[$]);
    int got;
    chk(tag, 64'(dut_log.size()), 64'(exp.size()));
    for (int i = 0; i < exp.size(); i++) begin
      got = (i < dut_log.size()) ? dut_log[i] : -1;
      chk(tag, 64'(got), 64'(exp[i]));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    clock_sreset  = 1'b1;
    m_address     = '0;
    m_writedata   = '0;
    m_read        = '0;
    m_write       = '0;
    s_waitrequest = 1'b0;
    s_readdata    = '0;
    @(posedge clock);
    @(negedge clock);
    model_busy = 1'b0; model_owner = 0; model_last = M - 1;
    cycle();
    clock_sreset = 1'b0;

    // Single master read.
    s_readdata = 32'h1357_9BDF;
    req_m(2, 1, 0, 12'h024, 32'h0);
    cycle();
    #1;
    chk("t1_s_read",   {63'd0, s_read}, 64'd1);
    chk("t1_s_addr",   64'(s_address), 64'h024);
    chk("t1_wait2",    {63'd0, m_waitrequest[2]}, 64'd0);
    chk("t1_readdata", 64'(m_readdata), 64'h1357_9BDF);
    drain("t1_drain", 20);

    // Contention: all four masters after reset-like state (last = 2 -> need reset).
    clock_sreset = 1'b1;
    cycle();
    clock_sreset = 1'b0;
    dut_log.delete(); dut_cyc.delete();
    for (int i = 0; i < M; i++) req_m(i, 1, 0, WA'(12'h100 + i), 32'h0);
    drain("t2_drain", 40);
    exp_q = {0, 1, 2, 3};
    check_log("t2_order", exp_q);
    for (int i = 1; i < dut_cyc.size(); i++)
      chk("t2_spacing", 64'(dut_cyc[i] - dut_cyc[i-1]), 64'd2);

    // Wait states on master 1 with master 0 contending.
    dut_log.delete();
    s_waitrequest = 1'b1;
    req_m(1, 0, 1, 12'h1e0, 32'hDEAD_BEEF);
    cycle();
    req_m(0, 1, 0, 12'h111, 32'h0);
    for (int j = 0; j < 6; j++) begin
      if (j == 5) s_waitrequest = 1'b0;
      #1;
      chk("t3_s_write", {63'd0, s_write}, 64'd1);
      chk("t3_addr",    64'(s_address), 64'h1e0);
      chk("t3_data",    64'(s_writedata), 64'hDEAD_BEEF);
      chk("t3_wait0",   {63'd0, m_waitrequest[0]}, 64'd1);
      cycle();
    end
    drain("t3_drain", 20);
    exp_q = {1, 0};
    check_log("t3_order", exp_q);

    // Round-robin wrap: serve master 3 so last = 3, then 0 and 3 contend.
    req_m(3, 1, 0, 12'h333, 32'h0);
    drain("t4_pre", 20);
    dut_log.delete();
    req_m(0, 0, 1, 12'h000, 32'h0000_00AA);
    req_m(3, 1, 0, 12'h3f3, 32'h0);
    drain("t4_drain", 20);
    exp_q = {0, 3};
    check_log("t4_order", exp_q);

    // Abandon: master 1 withdraws while stalled.
    s_waitrequest = 1'b1;
    req_m(1, 1, 0, 12'h0a1, 32'h0);
    cycle();
    cycle();
    m_read[1] = 1'b0;
    cycle();
    #1;
    chk("t5_s_read", {63'd0, s_read}, 64'd0);
    chk("t5_wait",   64'(m_waitrequest), 64'hF);
    s_waitrequest = 1'b0;
    dut_log.delete();
    req_m(0, 1, 0, 12'h0b0, 32'h0);
    req_m(2, 1, 0, 12'h0b2, 32'h0);
    drain("t5_drain", 20);
    exp_q = {2, 0};
    check_log("t5_order", exp_q);

    // Reset in the middle of a stalled transaction.
    s_waitrequest = 1'b1;
    req_m(2, 1, 0, 12'h0c2, 32'h0);
    cycle();
    cycle();
    clock_sreset = 1'b1;
    cycle();
    clock_sreset = 1'b0;
    #1;
    chk("t6_s_read",  {63'd0, s_read},  64'd0);
    chk("t6_s_write", {63'd0, s_write}, 64'd0);
    chk("t6_wait",    64'(m_waitrequest), 64'hF);
    s_waitrequest = 1'b0;
    dut_log.delete();
    req_m(0, 1, 0, 12'h0c0, 32'h0);
    req_m(3, 0, 1, 12'h0c3, 32'h1234_5678);
    drain("t6_drain", 20);
    exp_q = {0, 2, 3};
    check_log("t6_order", exp_q);

    // Randomized engine traffic.
    for (int c = 0; c < 600; c++) begin
      s_waitrequest = 1'($urandom_range(0, 1));
      s_readdata    = $urandom;
      clock_sreset  = ($urandom_range(0, 199) == 0);
      for (int i = 0; i < M; i++) begin
        if (!(m_read[i] | m_write[i])) begin
          if ($urandom_range(0, 3) == 0) begin
            if ($urandom_range(0, 1) == 1) req_m(i, 1, 0, WA'($urandom), $urandom);
            else                           req_m(i, 0, 1, WA'($urandom), $urandom);
          end
        end else if ($urandom_range(0, 49) == 0) begin
          m_read[i]  = 1'b0;
          m_write[i] = 1'b0;
        end
      end
      cycle();
    end
    clock_sreset  = 1'b0;
    s_waitrequest = 1'b0;
    drain("rand_drain", 40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
